// File: rtl/rssb_pkg.sv
// Shared types and special addresses for the RSSB core.
// Memory-mapped I/O on addresses 3/4 is enabled by RSSB_MMIO_EN (see rssb_core).
package rssb_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [7:0] ADDR_IP   = 8'h00;
    localparam logic [7:0] ADDR_ACC  = 8'h01;
    localparam logic [7:0] ADDR_ZERO = 8'h02;
    localparam logic [7:0] ADDR_IN   = 8'h03;
    localparam logic [7:0] ADDR_OUT  = 8'h04;
    localparam logic [7:0] ADDR_HALT = 8'hFF;

    // Lowest operand address that always lives in physical memory.
    localparam logic [7:0] ADDR_FIRST_MEM = 8'h05;

endpackage

// File: rtl/rssb_alu.sv
// Reverse-subtract datapath: result = src - acc, borrow when src < acc.
module rssb_alu (
    input  logic [7:0] src,
    input  logic [7:0] acc,
    output logic [7:0] result,
    output logic       borrow
);

    logic [8:0] diff_s;

    // Ninth bit of a zero-extended subtract is the unsigned borrow.
    assign diff_s = {1'b0, src} - {1'b0, acc};
    assign result = diff_s[7:0];
    assign borrow = diff_s[8];

endmodule

// File: rtl/rssb_core.sv
// RSSB processor core: FETCH/LOAD/STORE/HALT sequencer driving memorySystem.
// Define RSSB_MMIO_EN to map address 3 to IN and address 4 to OUT.
module rssb_core #(
    parameter logic [7:0] RESET_IP = 8'h05
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire  [7:0] mem_data,
    output logic [7:0] mem_address,
    output logic       mem_we,
    output logic       mem_re,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       halted
);
    import rssb_pkg::*;

    state_t     state_r;
    logic [7:0] ip_r;
    logic [7:0] acc_r;
    logic [7:0] opnd_r;
    logic [7:0] result_r;
    logic       borrow_r;

    logic       opnd_mem_s;
    logic       in_sel_s;
    logic       out_sel_s;
    logic [7:0] src_s;
    logic [7:0] alu_result_s;
    logic       alu_borrow_s;
    logic       load_done_s;
    logic       store_done_s;

`ifdef RSSB_MMIO_EN
    assign opnd_mem_s = (opnd_r >= ADDR_FIRST_MEM);
    assign in_sel_s   = (opnd_r == ADDR_IN);
    assign out_sel_s  = (opnd_r == ADDR_OUT);
`else
    // Without MMIO, addresses 3 and 4 are plain memory operands.
    assign opnd_mem_s = (opnd_r >= ADDR_IN);
    assign in_sel_s   = 1'b0;
    assign out_sel_s  = 1'b0;
`endif

    assign load_done_s  = !(in_sel_s && !in_valid);
    assign store_done_s = !(out_sel_s && !out_ready);

    // Operand source mux: special registers, MMIO input or memory.
    always_comb begin
        src_s = mem_data;
        case (opnd_r)
            ADDR_IP:   src_s = ip_r;
            ADDR_ACC:  src_s = acc_r;
            ADDR_ZERO: src_s = 8'h00;
            default:   src_s = mem_data;
        endcase
        if (in_sel_s) begin
            src_s = in_data;
        end else if (out_sel_s) begin
            src_s = 8'h00;
        end else begin
            src_s = src_s;
        end
    end

    rssb_alu u_alu (
        .src    (src_s),
        .acc    (acc_r),
        .result (alu_result_s),
        .borrow (alu_borrow_s)
    );

    // Instruction sequencer and architectural state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= FETCH;
            ip_r     <= RESET_IP;
            acc_r    <= 8'h00;
            opnd_r   <= 8'h00;
            result_r <= 8'h00;
            borrow_r <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    opnd_r  <= mem_data;
                    state_r <= (mem_data == ADDR_HALT) ? HALT : LOAD;
                end
                LOAD: begin
                    if (load_done_s) begin
                        result_r <= alu_result_s;
                        borrow_r <= alu_borrow_s;
                        state_r  <= STORE;
                    end
                end
                STORE: begin
                    if (store_done_s) begin
                        acc_r   <= result_r;
                        // Writing IP is a jump: no increment, borrow ignored.
                        ip_r    <= (opnd_r == ADDR_IP) ? result_r
                                                       : ip_r + 8'd1 + {7'd0, borrow_r};
                        state_r <= FETCH;
                    end
                end
                HALT:    state_r <= HALT;
                default: state_r <= FETCH;
            endcase
        end
    end

    // Memory strobes and address, decoded from the registered state.
    always_comb begin
        mem_address = ip_r;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        case (state_r)
            FETCH: begin
                mem_address = ip_r;
                mem_re      = 1'b1;
            end
            LOAD: begin
                mem_address = opnd_r;
                mem_re      = opnd_mem_s;
            end
            STORE: begin
                mem_address = opnd_r;
                mem_we      = opnd_mem_s && !reset;
            end
            HALT: begin
                mem_address = ip_r;
            end
            default: begin
                mem_address = ip_r;
            end
        endcase
    end

    assign mem_data  = mem_we ? result_r : 8'hzz;

    assign in_ready  = (state_r == LOAD) && in_sel_s;
    assign out_valid = (state_r == STORE) && out_sel_s;
    assign out_data  = out_valid ? result_r : 8'h00;
    assign halted    = (state_r == HALT);

endmodule
